// File: rtl/prog_mem.sv
// Runtime-loadable program memory with registered fetch port and streaming loader.
// Optional macro PROG_MEM_PARITY_EN adds per-word even parity and a sticky parity_err output.
module prog_mem #(
    parameter int unsigned       ADDR_W       = 4,
    parameter int unsigned       DATA_W       = 8,
    parameter int unsigned       DEPTH        = 2**ADDR_W,
    parameter logic [DATA_W-1:0] DEFAULT_WORD = DATA_W'(8'b1111_0000)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] addr,
    input  logic              rd_en,
    output logic [DATA_W-1:0] out,
    output logic              busy,
    input  logic              ld_start,
    input  logic              ld_valid,
    input  logic              ld_last,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ready,
    output logic              ld_done,
    output logic [ADDR_W:0]   ld_count
`ifdef PROG_MEM_PARITY_EN
    ,
    output logic              parity_err
`endif
);

    localparam int unsigned CNT_W = ADDR_W + 1;
`ifdef PROG_MEM_PARITY_EN
    localparam int unsigned WORD_W = DATA_W + 1;
`else
    localparam int unsigned WORD_W = DATA_W;
`endif
    localparam logic [ADDR_W-1:0] LAST_WP = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_FILL = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   wp_q, wp_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                done_q, done_d;
    logic                busy_q, ld_ready_q;
    logic [DATA_W-1:0]   out_q;
    logic [WORD_W-1:0]   mem_q [DEPTH];

    logic                we_c;
    logic [DATA_W-1:0]   wdata_c;
    logic                addr_ok_c;
    logic [WORD_W-1:0]   rd_word_c;
    logic [WORD_W-1:0]   wword_c;
    logic [WORD_W-1:0]   reset_word_c;

`ifdef PROG_MEM_PARITY_EN
    logic                perr_q;
    assign wword_c      = {^wdata_c, wdata_c};
    assign reset_word_c = {^DEFAULT_WORD, DEFAULT_WORD};
`else
    assign wword_c      = wdata_c;
    assign reset_word_c = DEFAULT_WORD;
`endif

    assign addr_ok_c = (CNT_W'(addr) < CNT_W'(DEPTH));
    assign rd_word_c = addr_ok_c ? mem_q[addr] : reset_word_c;

    // Loader next-state: one write per cycle, either a handshake word or a pad word.
    always_comb begin
        state_d = state_q;
        wp_d    = wp_q;
        count_d = count_q;
        done_d  = 1'b0;
        we_c    = 1'b0;
        wdata_c = DEFAULT_WORD;
        unique case (state_q)
            ST_IDLE: begin
                if (ld_start) begin
                    state_d = ST_LOAD;
                    wp_d    = '0;
                    count_d = '0;
                end
            end
            ST_LOAD: begin
                if (ld_valid) begin
                    we_c    = 1'b1;
                    wdata_c = ld_data;
                    wp_d    = wp_q + 1'b1;
                    count_d = count_q + 1'b1;
                    if (wp_q == LAST_WP) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else if (ld_last) begin
                        state_d = ST_FILL;
                    end
                end
            end
            ST_FILL: begin
                we_c = 1'b1;
                wp_d = wp_q + 1'b1;
                if (wp_q == LAST_WP) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            wp_q       <= '0;
            count_q    <= '0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            ld_ready_q <= 1'b0;
            out_q      <= DEFAULT_WORD;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= reset_word_c;
            end
        end else begin
            state_q    <= state_d;
            wp_q       <= wp_d;
            count_q    <= count_d;
            done_q     <= done_d;
            busy_q     <= (state_d != ST_IDLE);
            ld_ready_q <= (state_d == ST_LOAD);
            if (we_c) begin
                mem_q[wp_q] <= wword_c;
            end
            // A CPU that fails to stall during a load fetches JMP 0.
            if (state_q != ST_IDLE) begin
                out_q <= DEFAULT_WORD;
            end else if (rd_en) begin
                out_q <= rd_word_c[DATA_W-1:0];
            end
        end
    end

`ifdef PROG_MEM_PARITY_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perr_q <= 1'b0;
        end else if (state_q == ST_IDLE && ld_start) begin
            perr_q <= 1'b0;
        end else if (state_q == ST_IDLE && rd_en && addr_ok_c && (^rd_word_c)) begin
            perr_q <= 1'b1;
        end
    end
    assign parity_err = perr_q;
`endif

    assign out      = out_q;
    assign busy     = busy_q;
    assign ld_ready = ld_ready_q;
    assign ld_done  = done_q;
    assign ld_count = count_q;

endmodule
